// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALUOp encodings, controller state and op class.
package riscv_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    // CLS_NONE doubles as the reset value and the "unknown opcode" result.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_LW   = 3'd3,
        CLS_SW   = 3'd4,
        CLS_BR   = 3'd5,
        CLS_JAL  = 3'd6,
        CLS_JALR = 3'd7
    } op_class_e;

    function automatic op_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_R_TYPE: return CLS_R;
            OP_I_TYPE: return CLS_I;
            OP_LW:     return CLS_LW;
            OP_SW:     return CLS_SW;
            OP_BR:     return CLS_BR;
            OP_JAL:    return CLS_JAL;
            OP_JALR:   return CLS_JALR;
            default:   return CLS_NONE;
        endcase
    endfunction

    function automatic logic [1:0] class_aluop(input op_class_e cls);
        case (cls)
            CLS_LW, CLS_SW:   return ALUOP_MEM;
            CLS_BR:           return ALUOP_BR;
            CLS_R, CLS_I:     return ALUOP_ARITH;
            CLS_JAL, CLS_JALR: return ALUOP_JUMP;
            default:          return ALUOP_MEM;
        endcase
    endfunction

    function automatic logic class_alusrc(input op_class_e cls);
        return (cls == CLS_LW) || (cls == CLS_SW) || (cls == CLS_I);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath.
// Handshake: IMemReq/MemRead/MemWrite act as valid and are held until the
// matching ready is high; a transfer completes in the cycle both are high.
// Ready inputs are ignored in every state that does not wait on them.
interface multicycle_controller_if;
    logic [6:0] Opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       IMemReq;
    logic       IRWrite;
    logic       PCWrite;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;
    logic       JalrSel;
    logic       Retire;
    logic       Illegal;
    logic       Timeout;
    logic [2:0] State;

    modport master (
        input  Opcode, imem_ready, dmem_ready,
        output IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, ALUOp, Branch, JalrSel, Retire,
               Illegal, Timeout, State
    );

    modport slave (
        output Opcode, imem_ready, dmem_ready,
        input  IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, ALUOp, Branch, JalrSel, Retire,
               Illegal, Timeout, State
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the last allowed wait cycle.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int LIMIT_INT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIMIT_INT);

    logic [CW-1:0] count_d, count_q;

    // count_q holds the number of earlier wait cycles, so the current cycle is
    // wait number count_q+1; expiry fires on wait number MEM_TIMEOUT.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (waiting && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (MEM_TIMEOUT > 0) && waiting && (count_q == LIMIT);
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait
// handshakes, wait timeout and illegal-opcode trap.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);
    state_e    state_d, state_q;
    op_class_e class_d, class_q;
    logic      illegal_d, illegal_q;
    logic      timeout_d, timeout_q;
    logic      waiting, expired, clear;

    logic       imem_req, ir_write, pc_write, alu_src, mem_to_reg, reg_write;
    logic       mem_read, mem_write, branch, jalr_sel, retire;
    logic [1:0] alu_op;

    assign waiting = ((state_q == S_FETCH) && !bus.imem_ready) ||
                     ((state_q == S_MEM)   && !bus.dmem_ready);
    assign clear   = (state_d != state_q);

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .waiting (waiting),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                class_d = classify(bus.Opcode);
                if (class_d == CLS_NONE) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    CLS_BR:         state_d = S_FETCH;
                    CLS_LW, CLS_SW: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = (class_q == CLS_LW) ? S_WB : S_FETCH;
                end else if (expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= CLS_NONE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Reset gates the whole decode so nothing pulses for an aborted instruction.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = ALUOP_MEM;
        branch     = 1'b0;
        jalr_sel   = 1'b0;
        retire     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = bus.imem_ready;
                end
                S_EXEC: begin
                    alu_op  = class_aluop(class_q);
                    alu_src = class_alusrc(class_q);
                    if (class_q == CLS_BR) begin
                        branch   = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    alu_op    = class_aluop(class_q);
                    alu_src   = class_alusrc(class_q);
                    mem_read  = (class_q == CLS_LW);
                    mem_write = (class_q == CLS_SW);
                    if ((class_q == CLS_SW) && bus.dmem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    alu_op     = class_aluop(class_q);
                    alu_src    = class_alusrc(class_q);
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    mem_to_reg = (class_q == CLS_LW);
                    branch     = (class_q == CLS_JAL);
                    jalr_sel   = (class_q == CLS_JALR);
                end
                default: ;
            endcase
        end
    end

    assign bus.IMemReq  = imem_req;
    assign bus.IRWrite  = ir_write;
    assign bus.PCWrite  = pc_write;
    assign bus.ALUSrc   = alu_src;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.RegWrite = reg_write;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.ALUOp    = alu_op;
    assign bus.Branch   = branch;
    assign bus.JalrSel  = jalr_sel;
    assign bus.Retire   = retire;
    assign bus.Illegal  = !reset && illegal_q;
    assign bus.Timeout  = !reset && timeout_q;
    assign bus.State    = reset ? 3'd0 : state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors
// are queued as stimulus is driven and compared against the sampled outputs.
module tb_multicycle_controller;
  localparam int W   = 18;
  localparam int TMO = 4;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BAD  = 7'b1111111;

  typedef struct packed {
    logic [2:0] state;
    logic       imemreq;
    logic       irwrite;
    logic       pcwrite;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
    logic       jalrsel;
    logic       retire;
    logic       illegal;
    logic       timeout;
  } ovec_t;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] sample_outputs();
    ovec_t v;
    v.state    = bus.State;
    v.imemreq  = bus.IMemReq;
    v.irwrite  = bus.IRWrite;
    v.pcwrite  = bus.PCWrite;
    v.alusrc   = bus.ALUSrc;
    v.memtoreg = bus.MemtoReg;
    v.regwrite = bus.RegWrite;
    v.memread  = bus.MemRead;
    v.memwrite = bus.MemWrite;
    v.aluop    = bus.ALUOp;
    v.branch   = bus.Branch;
    v.jalrsel  = bus.JalrSel;
    v.retire   = bus.Retire;
    v.illegal  = bus.Illegal;
    v.timeout  = bus.Timeout;
    return v;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  // driver: one clock cycle of inputs, then capture the outputs mid-cycle
  task automatic step(input logic im, input logic dm, input logic [6:0] op, input logic rst);
    @(posedge clk);
    #2;
    bus.imem_ready = im;
    bus.dmem_ready = dm;
    bus.Opcode     = op;
    reset          = rst;
    @(negedge clk);
    #1;
    act_q.push_back(sample_outputs());
  endtask

  task automatic push_trap(input logic ill, input logic tmo);
    ovec_t v;
    v = '0;
    v.state   = 3'd5;
    v.illegal = ill;
    v.timeout = tmo;
    exp_q.push_back(v);
  endtask

  task automatic push_reset_cycle();
    ovec_t v;
    v = '0;
    exp_q.push_back(v);
    step(rnd1(), rnd1(), rnd_op(), 1'b1);
  endtask

  // drives one instruction from FETCH entry and queues its expected cycles
  task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait);
    ovec_t v;
    logic [1:0] aluop;
    logic alusrc;
    logic is_lw, is_sw, is_br, is_jal, is_jalr;
    case (op)
      OPC_R:    begin aluop = 2'b10; alusrc = 1'b0; end
      OPC_I:    begin aluop = 2'b10; alusrc = 1'b1; end
      OPC_LW:   begin aluop = 2'b00; alusrc = 1'b1; end
      OPC_SW:   begin aluop = 2'b00; alusrc = 1'b1; end
      OPC_BR:   begin aluop = 2'b01; alusrc = 1'b0; end
      OPC_JAL:  begin aluop = 2'b11; alusrc = 1'b0; end
      OPC_JALR: begin aluop = 2'b11; alusrc = 1'b0; end
      default:  begin aluop = 2'b00; alusrc = 1'b0; end
    endcase
    is_lw = (op == OPC_LW); is_sw = (op == OPC_SW); is_br = (op == OPC_BR);
    is_jal = (op == OPC_JAL); is_jalr = (op == OPC_JALR);

    for (int i = 0; i < fwait; i++) begin
      v = '0; v.imemreq = 1'b1;
      exp_q.push_back(v);
      step(1'b0, rnd1(), rnd_op(), 1'b0);
    end
    v = '0; v.imemreq = 1'b1; v.irwrite = 1'b1;
    exp_q.push_back(v);
    step(1'b1, rnd1(), rnd_op(), 1'b0);

    v = '0; v.state = 3'd1;
    exp_q.push_back(v);
    step(rnd1(), rnd1(), op, 1'b0);

    v = '0; v.state = 3'd2; v.aluop = aluop; v.alusrc = alusrc;
    if (is_br) begin v.branch = 1'b1; v.pcwrite = 1'b1; v.retire = 1'b1; end
    exp_q.push_back(v);
    step(rnd1(), rnd1(), rnd_op(), 1'b0);
    if (is_br) return;

    if (is_lw || is_sw) begin
      for (int i = 0; i < mwait; i++) begin
        v = '0; v.state = 3'd3; v.aluop = aluop; v.alusrc = alusrc;
        v.memread = is_lw; v.memwrite = is_sw;
        exp_q.push_back(v);
        step(rnd1(), 1'b0, rnd_op(), 1'b0);
      end
      v = '0; v.state = 3'd3; v.aluop = aluop; v.alusrc = alusrc;
      v.memread = is_lw; v.memwrite = is_sw;
      v.pcwrite = is_sw; v.retire = is_sw;
      exp_q.push_back(v);
      step(rnd1(), 1'b1, rnd_op(), 1'b0);
      if (is_sw) return;
    end

    v = '0; v.state = 3'd4; v.aluop = aluop; v.alusrc = alusrc;
    v.regwrite = 1'b1; v.pcwrite = 1'b1; v.retire = 1'b1;
    v.memtoreg = is_lw; v.branch = is_jal; v.jalrsel = is_jalr;
    exp_q.push_back(v);
    step(rnd1(), rnd1(), rnd_op(), 1'b0);
  endtask

  task automatic test_reset();
    logic [W-1:0] e, a;
    for (int i = 0; i < 3; i++) push_reset_cycle();
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_r_type();
    logic [W-1:0] e, a;
    run_instr(OPC_R, 0, 0);
    run_instr(OPC_I, 1, 0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL r_i_type vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_lw_sw();
    logic [W-1:0] e, a;
    run_instr(OPC_LW, 0, 2);
    run_instr(OPC_SW, 0, 0);
    run_instr(OPC_LW, 0, 0);
    run_instr(OPC_SW, 1, 2);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL lw_sw vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, a;
    run_instr(OPC_BR, 0, 0);
    run_instr(OPC_JALR, 0, 0);
    run_instr(OPC_JAL, 0, 0);
    run_instr(OPC_BR, 2, 0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL back_to_back vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_ready_on_limit();
    logic [W-1:0] e, a;
    run_instr(OPC_SW, TMO - 1, TMO - 1);
    run_instr(OPC_LW, TMO - 1, TMO - 1);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL ready_on_limit vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] e, a;
    ovec_t v;
    v = '0; v.imemreq = 1'b1; v.irwrite = 1'b1;
    exp_q.push_back(v);
    step(1'b1, rnd1(), rnd_op(), 1'b0);
    v = '0; v.state = 3'd1;
    exp_q.push_back(v);
    step(rnd1(), rnd1(), OPC_BAD, 1'b0);
    for (int i = 0; i < 20; i++) begin
      push_trap(1'b1, 1'b0);
      step(rnd1(), rnd1(), rnd_op(), 1'b0);
    end
    push_reset_cycle();
    run_instr(OPC_R, 0, 0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL illegal vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_mem_timeout();
    logic [W-1:0] e, a;
    ovec_t v;
    v = '0; v.imemreq = 1'b1; v.irwrite = 1'b1;
    exp_q.push_back(v);
    step(1'b1, 1'b0, rnd_op(), 1'b0);
    v = '0; v.state = 3'd1;
    exp_q.push_back(v);
    step(rnd1(), 1'b0, OPC_SW, 1'b0);
    v = '0; v.state = 3'd2; v.alusrc = 1'b1;
    exp_q.push_back(v);
    step(rnd1(), 1'b0, rnd_op(), 1'b0);
    for (int i = 0; i < TMO; i++) begin
      v = '0; v.state = 3'd3; v.alusrc = 1'b1; v.memwrite = 1'b1;
      exp_q.push_back(v);
      step(rnd1(), 1'b0, rnd_op(), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      push_trap(1'b0, 1'b1);
      step(rnd1(), rnd1(), rnd_op(), 1'b0);
    end
    push_reset_cycle();
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL mem_timeout vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [W-1:0] e, a;
    ovec_t v;
    for (int i = 0; i < TMO; i++) begin
      v = '0; v.imemreq = 1'b1;
      exp_q.push_back(v);
      step(1'b0, rnd1(), rnd_op(), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      push_trap(1'b0, 1'b1);
      step(1'b1, rnd1(), rnd_op(), 1'b0);
    end
    push_reset_cycle();
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL fetch_timeout vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [W-1:0] e, a;
    ovec_t v;
    v = '0; v.imemreq = 1'b1; v.irwrite = 1'b1;
    exp_q.push_back(v);
    step(1'b1, 1'b0, rnd_op(), 1'b0);
    v = '0; v.state = 3'd1;
    exp_q.push_back(v);
    step(rnd1(), 1'b0, OPC_SW, 1'b0);
    v = '0; v.state = 3'd2; v.alusrc = 1'b1;
    exp_q.push_back(v);
    step(rnd1(), 1'b0, rnd_op(), 1'b0);
    v = '0; v.state = 3'd3; v.alusrc = 1'b1; v.memwrite = 1'b1;
    exp_q.push_back(v);
    step(rnd1(), 1'b0, rnd_op(), 1'b0);
    // reset rises in the second wait cycle while dmem_ready is offered
    v = '0;
    exp_q.push_back(v);
    step(1'b1, 1'b1, rnd_op(), 1'b1);
    run_instr(OPC_R, 0, 0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL reset_mid_mem vec%0d: got %b want %b", vectors, a, e);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.Opcode     = 7'd0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_sw();
    test_back_to_back();
    test_ready_on_limit();
    test_illegal();
    test_mem_timeout();
    test_fetch_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
